sha3_scanner_farm: RTL and testbench
====================================

# sha3_scanner_farm

Multi-core front end for SHA3 nonce scanning: latches one work unit from the host, fans it out to `CORES` external scanner cores with disjoint nonce sub-ranges, and collects every reported result into a small FIFO the host drains at its own pace. It sits between the AXI control logic and an array of `sha3_scanner` / `sha3_packed_pipeline_scanner` instances. Unlike the single-core instantiator, it does not lose simultaneous or back-to-back results: they queue, and drops are flagged explicitly.

## Interface
- `CORES`, 4: number of scanner cores, 1..8.
- `PROPER`, 1: selects `INPUT_ELEMENTS` = 20 (1) or 24 (0).
- `RESULT_DEPTH`, 4: result FIFO entries, power of two, ≥2.
- `NONCE_ELEMENT`, `INPUT_ELEMENTS-1`: index of the `blobby` word holding the starting nonce.
- Ports:
  - `clk` in 1: the only clock; all logic is on its rising edge.
  - `rst` in 1: synchronous, active-high reset.
  - `start` in 1: request; accepted only when `idle`.
  - `blobby` in 32×`INPUT_ELEMENTS`: work unit, latched on an accepted start.
  - `threshold` in 64: registered every cycle, forwarded as `core_threshold`.
  - `idle` out 1: ready to accept `start`.
  - `dispatching` out 1: registered OR of `core_dispatching`.
  - `awaiting` out 1: registered OR of `core_awaiting`.
  - `evaluating_count` out $clog2(CORES+1): registered popcount of `core_evaluating`.
  - `result_valid` out 1: FIFO head is valid (first-word fall-through).
  - `result_hash` out 64×25: FIFO head hash.
  - `result_nonce` out 32: FIFO head nonce.
  - `result_core` out max(1,$clog2(CORES)): index of the core that produced the head.
  - `result_pop` in 1: discards the head; ignored when `!result_valid`.
  - `overflow` out 1: sticky flag, a result was dropped.
  - `scan_count` out 32: registered `CORES*core_scan_count`, saturating at 0xFFFF_FFFF.
  - `core_scan_count` in 32: per-core nonce range; constant.
  - `core_start` out `CORES`: one-cycle launch pulse.
  - `core_blobby` out `CORES`×`INPUT_ELEMENTS`×32: per-core work unit.
  - `core_threshold` out 64: registered threshold.
  - `core_capture`, `core_dispatching`, `core_awaiting`, `core_evaluating` in `CORES` each: per-core status strobes.
  - `core_hash` in `CORES`×25×64: per-core result hash.
  - `core_nonce` in `CORES`×32: per-core result nonce.

## Operation
- **FSM states:**
  - IDLE → LAUNCH when `start & idle`; the accepting cycle is the strobe.
  - LAUNCH lasts 1 cycle → RUN.
  - RUN → IDLE when `dispatch_seen & ~|core_awaiting`.
  - `dispatch_seen` clears on entering LAUNCH and sets on any `core_dispatching`.
  - `idle` = (state == IDLE).
- **Nonce split:**
  - `core_blobby[k]` = latched `blobby`, except word `NONCE_ELEMENT`, which is `base + k*core_scan_count` mod 2^32 (wraps silently).
  - `core_blobby` holds its value until the next accepted start.
- **Capture path:**
  - Each core has a one-entry pending register (hash, nonce, valid).
  - `core_capture[k]` loads pending[k] if it is empty.
  - If pending[k] is full and not being drained that cycle, the new result is dropped and `overflow` is set.
  - Each cycle, the lowest-index valid pending entry moves into the FIFO if the FIFO is not full. Otherwise it waits; there is no loss while pending has room.
  - A drain and a fresh capture of the same core in the same cycle: the old entry goes to the FIFO and the new one is loaded into pending.
- **FIFO:**
  - Push and pop in the same cycle is legal when full or non-empty; the count is unchanged.
  - A pop when empty is ignored.
- **Accepted start:**
  - Flushes the FIFO and all pending registers.
  - Clears `overflow`.
  - A capture in the strobe cycle is discarded.
- **Reset values:**
  - `idle`=1.
  - All other outputs 0: `result_*`, `overflow`, `dispatching`, `awaiting`, `evaluating_count`, `core_start`, `core_blobby`, `core_threshold`, `scan_count`.
- **Reset mid-RUN** forces IDLE and clears everything. Cores are not reset by this block.

## Timing
- Strobe at cycle t:
  - `idle`=0 at t+1.
  - `core_start`=1 at t+1 only, with `core_blobby` valid at t+1.
- `core_capture[k]` at c:
  - pending at c+1.
  - FIFO at c+2.
  - `result_valid` at c+2 if the FIFO was empty and no lower-index pending entry competes.
- `result_pop` at p: the next head (or `result_valid`=0) is visible at p+1.
- Status outputs lag the core inputs by 1 cycle.
- `scan_count` lags `core_scan_count` by 1 cycle.
- Minimum start-to-idle: 3 cycles, for a core that dispatches and finishes immediately.

## Test plan
- **Reset and idle:** reset with `CORES`=4, `core_scan_count`=0x1000 → `idle`=1 and `scan_count`=0x4000 after 1 cycle.
- **Nonce split:** start with nonce word 0xFFFF_F800 → single `core_start` pulse 1 cycle later; core nonces 0xFFFF_F800, 0x0000_0800, 0x0000_1800, 0x0000_2800.
- **Simultaneous captures:** cores 0 and 2 capture in the same cycle (nonces 0xA, 0xC) → heads at c+2 and c+3 with `result_core` 0 then 2, nonces 0xA then 0xC; no `overflow`.
- **Overflow:** with no pops, core 1 captures 6 times on consecutive cycles with `RESULT_DEPTH`=4 → FIFO holds the first 4, pending holds the 5th, the 6th is dropped, `overflow`=1. Popping all five yields nonces in order.
- **Completion:** core 3 is the last to drop `core_awaiting` → `idle`=1 on the following cycle. A `start` while busy is ignored (no `core_start`).
- **Restart flush:** a new start while `result_valid`=1 and `overflow`=1 → FIFO empty and `overflow`=0 at t+1. Reset asserted mid-RUN → all reset values restored at the next cycle.

Source files
------------

// File: rtl/sha3_scanner_farm.sv
// Multi-core SHA3 nonce-scan front end: splits one work unit across CORES
// scanner cores and queues every reported result for the host.
module sha3_scanner_farm #(
    parameter int CORES          = 4,
    parameter int PROPER         = 1,
    parameter int RESULT_DEPTH   = 4,
    parameter int INPUT_ELEMENTS = (PROPER != 0) ? 20 : 24,
    parameter int NONCE_ELEMENT  = INPUT_ELEMENTS - 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [32*INPUT_ELEMENTS-1:0]           blobby,
    input  logic [63:0]                            threshold,
    output logic                                   idle,
    output logic                                   dispatching,
    output logic                                   awaiting,
    output logic [$clog2(CORES+1)-1:0]             evaluating_count,
    output logic                                   result_valid,
    output logic [64*25-1:0]                       result_hash,
    output logic [31:0]                            result_nonce,
    output logic [((CORES > 1) ? $clog2(CORES) : 1)-1:0] result_core,
    input  logic                                   result_pop,
    output logic                                   overflow,
    output logic [31:0]                            scan_count,
    input  logic [31:0]                            core_scan_count,
    output logic [CORES-1:0]                       core_start,
    output logic [CORES*INPUT_ELEMENTS*32-1:0]     core_blobby,
    output logic [63:0]                            core_threshold,
    input  logic [CORES-1:0]                       core_capture,
    input  logic [CORES-1:0]                       core_dispatching,
    input  logic [CORES-1:0]                       core_awaiting,
    input  logic [CORES-1:0]                       core_evaluating,
    input  logic [CORES*25*64-1:0]                 core_hash,
    input  logic [CORES*32-1:0]                    core_nonce
);
    localparam int CW = (CORES > 1) ? $clog2(CORES) : 1;
    localparam int EW = $clog2(CORES + 1);
    localparam int AW = $clog2(RESULT_DEPTH);
    localparam int BW = 32 * INPUT_ELEMENTS;
    localparam int HW = 25 * 64;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN} state_t;

    state_t state, state_next;
    logic   dispatch_seen;
    logic   strobe;

    assign idle   = (state == S_IDLE);
    assign strobe = start & idle;

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (start) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_RUN;
            S_RUN:    if (dispatch_seen && !(|core_awaiting)) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            dispatch_seen <= 1'b0;
        end else begin
            state <= state_next;
            if (strobe) dispatch_seen <= 1'b0;
            else if (|core_dispatching) dispatch_seen <= 1'b1;
        end
    end

    // Each core gets the same unit with its nonce offset by k ranges.
    logic [CORES*BW-1:0] blob_next;
    always_comb begin
        blob_next = '0;
        for (int k = 0; k < CORES; k++) begin
            blob_next[k*BW +: BW] = blobby;
            blob_next[k*BW + NONCE_ELEMENT*32 +: 32] =
                blobby[NONCE_ELEMENT*32 +: 32] + 32'(k) * core_scan_count;
        end
    end

    logic [35:0]   scan_full;
    logic [EW-1:0] eval_sum;
    assign scan_full = 36'(CORES) * {4'd0, core_scan_count};

    always_comb begin
        eval_sum = '0;
        for (int k = 0; k < CORES; k++) eval_sum = eval_sum + EW'(core_evaluating[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            core_start       <= '0;
            core_blobby      <= '0;
            core_threshold   <= '0;
            dispatching      <= 1'b0;
            awaiting         <= 1'b0;
            evaluating_count <= '0;
            scan_count       <= '0;
        end else begin
            core_start       <= {CORES{strobe}};
            if (strobe) core_blobby <= blob_next;
            core_threshold   <= threshold;
            dispatching      <= |core_dispatching;
            awaiting         <= |core_awaiting;
            evaluating_count <= eval_sum;
            scan_count       <= (|scan_full[35:32]) ? 32'hFFFF_FFFF : scan_full[31:0];
        end
    end

    logic [CORES-1:0] p_valid;
    logic [HW-1:0]    p_hash  [CORES];
    logic [31:0]      p_nonce [CORES];
    logic [CW-1:0]    sel;
    logic [CORES-1:0] drain;
    logic [CORES-1:0] load;
    logic [AW:0]      count;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             fifo_full, pop_eff, push;

    assign fifo_full = (count == (AW+1)'(RESULT_DEPTH));
    assign pop_eff   = result_pop & (count != '0);
    assign push      = (|p_valid) & (~fifo_full | pop_eff);

    always_comb begin
        sel = '0;
        for (int k = CORES - 1; k >= 0; k--) if (p_valid[k]) sel = CW'(k);
    end

    always_comb begin
        drain = '0;
        load  = '0;
        for (int k = 0; k < CORES; k++) begin
            drain[k] = push && (sel == CW'(k));
            load[k]  = core_capture[k] & ~strobe & (~p_valid[k] | drain[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || strobe) begin
            p_valid  <= '0;
            overflow <= 1'b0;
        end else begin
            for (int k = 0; k < CORES; k++) begin
                if (load[k]) p_valid[k] <= 1'b1;
                else if (drain[k]) p_valid[k] <= 1'b0;
            end
            if (|(core_capture & p_valid & ~drain)) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < CORES; k++) begin
            if (load[k]) begin
                p_hash[k]  <= core_hash[k*HW +: HW];
                p_nonce[k] <= core_nonce[k*32 +: 32];
            end
        end
    end

    logic [HW-1:0] mem_hash  [RESULT_DEPTH];
    logic [31:0]   mem_nonce [RESULT_DEPTH];
    logic [CW-1:0] mem_core  [RESULT_DEPTH];

    always_ff @(posedge clk) begin
        if (rst || strobe) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_hash[wr_ptr]  <= p_hash[sel];
            mem_nonce[wr_ptr] <= p_nonce[sel];
            mem_core[wr_ptr]  <= sel;
        end
    end

    // Head is zeroed when empty so stale entries never leak out.
    assign result_valid = (count != '0);
    assign result_hash  = result_valid ? mem_hash[rd_ptr]  : '0;
    assign result_nonce = result_valid ? mem_nonce[rd_ptr] : '0;
    assign result_core  = result_valid ? mem_core[rd_ptr]  : '0;

endmodule

// File: tb/tb_sha3_scanner_farm.sv
// Directed bench for sha3_scanner_farm: status table, nonce split table,
// and hand sequences for capture queueing, overflow, completion and flush.
module tb_sha3_scanner_farm;
    localparam int CORES = 4;
    localparam int IE    = 20;
    localparam int BW    = 32 * IE;
    localparam int HW    = 1600;
    localparam int NE    = IE - 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [BW-1:0]        blobby;
    logic [63:0]          threshold;
    logic                 idle, dispatching, awaiting;
    logic [2:0]           evaluating_count;
    logic                 result_valid;
    logic [HW-1:0]        result_hash;
    logic [31:0]          result_nonce;
    logic [1:0]           result_core;
    logic                 result_pop;
    logic                 overflow;
    logic [31:0]          scan_count;
    logic [31:0]          core_scan_count;
    logic [CORES-1:0]     core_start;
    logic [CORES*BW-1:0]  core_blobby;
    logic [63:0]          core_threshold;
    logic [CORES-1:0]     core_capture, core_dispatching, core_awaiting, core_evaluating;
    logic [CORES*HW-1:0]  core_hash;
    logic [CORES*32-1:0]  core_nonce;

    sha3_scanner_farm #(.CORES(4), .PROPER(1), .RESULT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .blobby(blobby),
        .threshold(threshold), .idle(idle), .dispatching(dispatching),
        .awaiting(awaiting), .evaluating_count(evaluating_count),
        .result_valid(result_valid), .result_hash(result_hash),
        .result_nonce(result_nonce), .result_core(result_core),
        .result_pop(result_pop), .overflow(overflow), .scan_count(scan_count),
        .core_scan_count(core_scan_count), .core_start(core_start),
        .core_blobby(core_blobby), .core_threshold(core_threshold),
        .core_capture(core_capture), .core_dispatching(core_dispatching),
        .core_awaiting(core_awaiting), .core_evaluating(core_evaluating),
        .core_hash(core_hash), .core_nonce(core_nonce)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] disp, aw, ev;
        logic       ed, ea;
        logic [2:0] ee;
    } stat_t;

    typedef struct {
        int         k;
        logic [31:0] nonce;
    } split_t;

    stat_t  stv[5];
    split_t spv[4];

    initial begin
        stv[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'd0};
        stv[1] = '{4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 3'd0};
        stv[2] = '{4'b0000, 4'b1000, 4'b1011, 1'b0, 1'b1, 3'd3};
        stv[3] = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b1, 3'd4};
        stv[4] = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 3'd1};
        spv[0] = '{0, 32'hFFFF_F800};
        spv[1] = '{1, 32'h0000_0800};
        spv[2] = '{2, 32'h0000_1800};
        spv[3] = '{3, 32'h0000_2800};

        rst = 1'b1; start = 1'b0; blobby = '0; threshold = 64'h0123_4567_89AB_CDEF;
        result_pop = 1'b0; core_scan_count = 32'h1000;
        core_capture = '0; core_dispatching = '0; core_awaiting = '0;
        core_evaluating = '0; core_hash = '0; core_nonce = '0;
        step(); step();

        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_scan", 64'(scan_count), 64'd0);
        chk("reset_valid", 64'(result_valid), 64'd0);
        chk("reset_thr", core_threshold, 64'd0);
        chk("reset_start", 64'(core_start), 64'd0);

        rst = 1'b0;
        step();
        chk("scan_count", 64'(scan_count), 64'h4000);
        chk("thr_fwd", core_threshold, 64'h0123_4567_89AB_CDEF);
        chk("idle_after", 64'(idle), 64'd1);

        core_scan_count = 32'h5000_0000;
        step();
        chk("scan_sat", 64'(scan_count), 64'hFFFF_FFFF);
        core_scan_count = 32'h1000;
        step();

        for (int i = 0; i < 5; i++) begin
            core_dispatching = stv[i].disp;
            core_awaiting    = stv[i].aw;
            core_evaluating  = stv[i].ev;
            step();
            chk($sformatf("stat%0d_disp", i), 64'(dispatching), 64'(stv[i].ed));
            chk($sformatf("stat%0d_await", i), 64'(awaiting), 64'(stv[i].ea));
            chk($sformatf("stat%0d_eval", i), 64'(evaluating_count), 64'(stv[i].ee));
        end
        core_dispatching = '0; core_awaiting = '0; core_evaluating = '0;

        for (int w = 0; w < IE; w++) blobby[w*32 +: 32] = 32'hC0DE_0000 + 32'(w);
        blobby[NE*32 +: 32] = 32'hFFFF_F800;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("launch_idle", 64'(idle), 64'd0);
        chk("launch_pulse", 64'(core_start), 64'hF);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("split_nonce%0d", spv[i].k),
                64'(core_blobby[spv[i].k*BW + NE*32 +: 32]), 64'(spv[i].nonce));
            chk($sformatf("split_word0_%0d", spv[i].k),
                64'(core_blobby[spv[i].k*BW +: 32]), 64'hC0DE_0000);
        end
        core_dispatching = 4'hF; core_awaiting = 4'hF;
        blobby = '0;
        step();
        core_dispatching = '0;
        chk("pulse_single", 64'(core_start), 64'd0);
        chk("blob_hold", 64'(core_blobby[BW + NE*32 +: 32]), 64'h0000_0800);
        chk("disp_reg", 64'(dispatching), 64'd1);

        core_capture = 4'b0101;
        core_nonce[0 +: 32]  = 32'hA;
        core_nonce[64 +: 32] = 32'hC;
        core_hash[0 +: 64]      = 64'hAAAA_0000_0000_000A;
        core_hash[2*HW +: 64]   = 64'hCCCC_0000_0000_000C;
        step();
        core_capture = '0;
        chk("sim_c1_valid", 64'(result_valid), 64'd0);
        step();
        chk("sim_c2_valid", 64'(result_valid), 64'd1);
        chk("sim_c2_core", 64'(result_core), 64'd0);
        chk("sim_c2_nonce", 64'(result_nonce), 64'hA);
        chk("sim_c2_hash", result_hash[63:0], 64'hAAAA_0000_0000_000A);
        result_pop = 1'b1;
        step();
        result_pop = 1'b0;
        chk("sim_c3_valid", 64'(result_valid), 64'd1);
        chk("sim_c3_core", 64'(result_core), 64'd2);
        chk("sim_c3_nonce", 64'(result_nonce), 64'hC);
        chk("sim_c3_hash", result_hash[63:0], 64'hCCCC_0000_0000_000C);
        result_pop = 1'b1;
        step();
        result_pop = 1'b0;
        chk("sim_empty", 64'(result_valid), 64'd0);
        chk("sim_no_ovf", 64'(overflow), 64'd0);
        result_pop = 1'b1;
        step();
        result_pop = 1'b0;
        chk("pop_empty", 64'(result_valid), 64'd0);

        for (int i = 1; i <= 6; i++) begin
            core_capture = 4'b0010;
            core_nonce[32 +: 32] = 32'(i);
            step();
        end
        core_capture = '0;
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", 64'(result_nonce), 64'd1);
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("ovf_pop%0d_valid", i), 64'(result_valid), 64'd1);
            chk($sformatf("ovf_pop%0d_nonce", i), 64'(result_nonce), 64'(i));
            chk($sformatf("ovf_pop%0d_core", i), 64'(result_core), 64'd1);
            result_pop = 1'b1;
            step();
            result_pop = 1'b0;
        end
        chk("ovf_drained", 64'(result_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        core_capture = 4'b0001;
        core_nonce[0 +: 32] = 32'h77;
        step();
        core_capture = '0;
        step();
        chk("pre_flush_valid", 64'(result_valid), 64'd1);

        core_awaiting = 4'b1000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_no_start", 64'(core_start), 64'd0);
        chk("busy_idle", 64'(idle), 64'd0);
        core_awaiting = '0;
        step();
        chk("complete_idle", 64'(idle), 64'd1);

        start = 1'b1;
        core_capture = 4'b0001;
        step();
        start = 1'b0;
        core_capture = '0;
        chk("flush_valid", 64'(result_valid), 64'd0);
        chk("flush_ovf", 64'(overflow), 64'd0);
        chk("flush_pulse", 64'(core_start), 64'hF);
        core_dispatching = 4'b0001;
        step();
        core_dispatching = '0;
        chk("min_t2_idle", 64'(idle), 64'd0);
        step();
        chk("min_t3_idle", 64'(idle), 64'd1);
        chk("strobe_cap_drop", 64'(result_valid), 64'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        core_awaiting = 4'hF;
        step();
        core_capture = 4'b0100;
        step();
        core_capture = '0;
        step();
        chk("pre_rst_valid", 64'(result_valid), 64'd1);
        chk("pre_rst_idle", 64'(idle), 64'd0);
        rst = 1'b1;
        step();
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_nonce", 64'(result_nonce), 64'd0);
        chk("rst_blob", 64'(core_blobby[BW + NE*32 +: 32]), 64'd0);
        chk("rst_await", 64'(awaiting), 64'd0);
        chk("rst_scan", 64'(scan_count), 64'd0);
        chk("rst_thr", core_threshold, 64'd0);
        rst = 1'b0;
        core_awaiting = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
